// File: rtl/touch_sense_pkg.sv
// Shared constants for the touch pad sensing core: register map, identity words
// and debounce FSM state encoding.
package touch_sense_pkg;

    localparam logic [7:0] ADDR_NAME0   = 8'h00;
    localparam logic [7:0] ADDR_NAME1   = 8'h01;
    localparam logic [7:0] ADDR_VERSION = 8'h02;
    localparam logic [7:0] ADDR_CTRL    = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h09;
    localparam logic [7:0] ADDR_COUNT   = 8'h0a;

    localparam logic [31:0] NAME0 = 32'h746f7563;  // "touc"
    localparam logic [31:0] NAME1 = 32'h68736e73;  // "hsns"

    localparam logic [1:0] ST_IDLE_LO    = 2'd0;
    localparam logic [1:0] ST_CONFIRM_HI = 2'd1;
    localparam logic [1:0] ST_IDLE_HI    = 2'd2;
    localparam logic [1:0] ST_CONFIRM_LO = 2'd3;

endpackage

// File: rtl/touch_debounce.sv
// Pad synchroniser plus a four-state debounce FSM; emits the accepted level and a
// single-cycle pulse on each accepted rising transition.
module touch_debounce
    import touch_sense_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 25000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic pad,
    output logic level,
    output logic rise_pulse
);

    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [15:0]            count;
    logic [15:0]            count_next;
    logic                   fire;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            state <= ST_IDLE_LO;
            count <= '0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], pad};
            state <= state_next;
            count <= count_next;
        end
    end

    // With LAST == 0 a differing sample is accepted straight from the idle states.
    always_comb begin
        state_next = state;
        count_next = count;
        fire       = 1'b0;
        case (state)
            ST_IDLE_LO: begin
                if (s) begin
                    if (LAST == 16'd0) begin
                        state_next = ST_IDLE_HI;
                        fire       = 1'b1;
                    end else begin
                        state_next = ST_CONFIRM_HI;
                        count_next = 16'd1;
                    end
                end
            end
            ST_CONFIRM_HI: begin
                if (!s) begin
                    state_next = ST_IDLE_LO;
                    count_next = 16'd0;
                end else if (count == LAST) begin
                    state_next = ST_IDLE_HI;
                    count_next = 16'd0;
                    fire       = 1'b1;
                end else begin
                    count_next = count + 16'd1;
                end
            end
            ST_IDLE_HI: begin
                if (!s) begin
                    if (LAST == 16'd0) begin
                        state_next = ST_IDLE_LO;
                    end else begin
                        state_next = ST_CONFIRM_LO;
                        count_next = 16'd1;
                    end
                end
            end
            default: begin
                if (s) begin
                    state_next = ST_IDLE_HI;
                    count_next = 16'd0;
                end else if (count == LAST) begin
                    state_next = ST_IDLE_LO;
                    count_next = 16'd0;
                end else begin
                    count_next = count + 16'd1;
                end
            end
        endcase
        if (!enable) begin
            state_next = ST_IDLE_LO;
            count_next = 16'd0;
            fire       = 1'b0;
        end
    end

    assign level      = (state == ST_IDLE_HI) || (state == ST_CONFIRM_LO);
    assign rise_pulse = fire;

endmodule

// File: rtl/touch_sense.sv
// MMIO touch pad core: register bank, sticky event flag, event counter and the
// single-cycle cs/ready access handshake.
module touch_sense
    import touch_sense_pkg::*;
#(
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 25000,
    parameter logic [31:0] CORE_VERSION    = 32'h00000001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        touch_event,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready
);

    logic        enable;
    logic        event_flag;
    logic [15:0] event_count;
    logic        level;
    logic        rise_pulse;
    logic        cs_held;
    logic        start;
    logic        ctrl_write;
    logic        status_write;
    logic [31:0] rdata;
    logic        unused_write_bits;

    touch_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pad        (touch_event),
        .level      (level),
        .rise_pulse (rise_pulse)
    );

    // cs_held stops a long-held chip select from starting a second access.
    assign start        = cs && !cs_held && !ready;
    assign ctrl_write   = start && we && (address == ADDR_CTRL);
    assign status_write = start && we && (address == ADDR_STATUS);

    assign unused_write_bits = ^write_data[31:1];

    always_comb begin
        rdata = '0;
        case (address)
            ADDR_NAME0:   rdata = NAME0;
            ADDR_NAME1:   rdata = NAME1;
            ADDR_VERSION: rdata = CORE_VERSION;
            ADDR_CTRL:    rdata = {31'd0, enable};
            ADDR_STATUS:  rdata = {30'd0, level, event_flag};
            ADDR_COUNT:   rdata = {16'd0, event_count};
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_data   <= '0;
            ready       <= 1'b0;
            cs_held     <= 1'b0;
            enable      <= 1'b1;
            event_flag  <= 1'b0;
            event_count <= '0;
        end else begin
            ready   <= start;
            cs_held <= cs;
            if (start) begin
                read_data <= rdata;
            end
            if (ctrl_write) begin
                enable <= write_data[0];
            end
            // A new event outranks a firmware clear landing on the same cycle.
            if (rise_pulse) begin
                event_flag <= 1'b1;
            end else if (status_write) begin
                event_flag <= 1'b0;
            end
            if (rise_pulse) begin
                event_count <= event_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_touch_sense.sv
// Scoreboard bench for touch_sense with a short debounce window.
module tb_touch_sense;
    import touch_sense_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        touch_event = 1'b0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    bit          chk_q[$];
    string       tag_q[$];

    logic [31:0] mon_exp;
    bit          mon_chk;
    string       mon_tag;

    touch_sense #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CORE_VERSION    (32'h00000001)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .touch_event (touch_event),
        .cs          (cs),
        .we          (we),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    task automatic check_result(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one access with cs held for 'hold' cycles and checks the ready pulse.
    task automatic access(input bit w, input logic [7:0] a, input logic [31:0] d,
                          input bit chk, input logic [31:0] exp, input string tag, input int hold);
        int pulses;
        int first_at;
        pulses   = 0;
        first_at = -1;
        exp_q.push_back(exp);
        chk_q.push_back(chk);
        tag_q.push_back(tag);
        cs = 1'b1;
        we = w;
        address = a;
        write_data = d;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        cs = 1'b0;
        we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            if (ready) pulses++;
        end
        if (pulses == 0 && exp_q.size() > 0) begin
            void'(exp_q.pop_back());
            void'(chk_q.pop_back());
            void'(tag_q.pop_back());
        end
        check_result({tag, "_ready_pulses"}, 32'(pulses), 32'd1);
        check_result({tag, "_ready_latency"}, 32'(first_at), 32'd0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
        access(1'b0, a, 32'h0, 1'b1, exp, tag, 1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input string tag);
        access(1'b1, a, d, 1'b0, 32'h0, tag, 1);
    endtask

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_result("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_chk = chk_q.pop_front();
                mon_tag = tag_q.pop_front();
                if (mon_chk) check_result(mon_tag, read_data, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        cycles(3);
        check_result("reset_ready", {31'd0, ready}, 32'd0);
        check_result("reset_read_data", read_data, 32'd0);
        reset = 1'b0;
        cycles(2);

        access(1'b0, ADDR_NAME0, 32'h0, 1'b1, 32'h746f7563, "name0_hold3", 3);
        rd(ADDR_NAME1, 32'h68736e73, "name1");
        rd(ADDR_VERSION, 32'h00000001, "version");
        rd(ADDR_CTRL, 32'h1, "ctrl_reset");
        rd(8'h05, 32'h0, "unmapped");

        // Glitch shorter than the debounce window.
        touch_event = 1'b1;
        cycles(3);
        touch_event = 1'b0;
        cycles(10);
        rd(ADDR_STATUS, 32'h0, "status_glitch");
        rd(ADDR_COUNT, 32'h0, "count_glitch");

        // Real press: flag expected 2 sync + 4 debounce cycles after the edge.
        touch_event = 1'b1;
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            cycles(1);
            if (dut.event_flag) n = i;
        end
        check_result("rise_latency_in_window", {31'd0, (n >= 5 && n <= 7)}, 32'd1);
        cycles(4);
        rd(ADDR_STATUS, 32'h3, "status_press");
        rd(ADDR_COUNT, 32'h1, "count_press");

        wr(ADDR_STATUS, 32'hdeadbeef, "status_clear_wr");
        rd(ADDR_STATUS, 32'h2, "status_cleared");

        // Release, then time a STATUS write onto the rise pulse.
        touch_event = 1'b0;
        cycles(12);
        rd(ADDR_STATUS, 32'h0, "status_released");
        touch_event = 1'b1;
        cycles(5);
        check_result("rise_coincides", {31'd0, dut.rise_pulse}, 32'd1);
        wr(ADDR_STATUS, 32'h0, "status_clear_race");
        rd(ADDR_STATUS, 32'h3, "status_set_wins");
        rd(ADDR_COUNT, 32'h2, "count_race");

        // Disabled: pad activity ignored, flag and count retained.
        touch_event = 1'b0;
        cycles(12);
        wr(ADDR_CTRL, 32'h0, "ctrl_off_wr");
        rd(ADDR_CTRL, 32'h0, "ctrl_off");
        for (int k = 0; k < 5; k++) begin
            touch_event = 1'b1;
            cycles(10);
            touch_event = 1'b0;
            cycles(10);
        end
        rd(ADDR_COUNT, 32'h2, "count_disabled");
        rd(ADDR_STATUS, 32'h1, "status_disabled");
        touch_event = 1'b1;
        cycles(5);
        wr(ADDR_CTRL, 32'h1, "ctrl_on_wr");
        cycles(10);
        rd(ADDR_COUNT, 32'h3, "count_reenable");
        cycles(20);
        rd(ADDR_COUNT, 32'h3, "count_reenable_once");
        rd(ADDR_STATUS, 32'h3, "status_reenable");

        // Counter wrap from 0xffff.
        force dut.event_count = 16'hffff;
        cycles(1);
        release dut.event_count;
        rd(ADDR_COUNT, 32'h0000ffff, "count_forced");
        touch_event = 1'b0;
        cycles(12);
        touch_event = 1'b1;
        cycles(12);
        rd(ADDR_COUNT, 32'h0, "count_wrap");

        // Reset while confirming a press and with an access in flight.
        touch_event = 1'b0;
        cycles(12);
        touch_event = 1'b1;
        cycles(3);
        cs = 1'b1;
        we = 1'b0;
        address = ADDR_NAME0;
        reset = 1'b1;
        cycles(1);
        check_result("abort_ready", {31'd0, ready}, 32'd0);
        check_result("abort_read_data", read_data, 32'd0);
        reset = 1'b0;
        cs = 1'b0;
        touch_event = 1'b0;
        cycles(1);
        check_result("abort_no_late_ready", {31'd0, ready}, 32'd0);
        cycles(2);
        rd(ADDR_STATUS, 32'h0, "status_after_reset");
        rd(ADDR_COUNT, 32'h0, "count_after_reset");
        rd(ADDR_CTRL, 32'h1, "ctrl_after_reset");

        wr(ADDR_CTRL, 32'h0, "ctrl_off_again");
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(1);
        rd(ADDR_CTRL, 32'h1, "ctrl_reset_again");

        cycles(2);
        check_result("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
